mux4way_rr: RTL
===============

# mux4way_rr

Four-channel round-robin collector with valid/ready handshakes; it merges four input streams into one registered output stream. Each output beat carries a 2-bit `out_sel` tag naming the source channel. This is the gathering end of the 4-way distribution path: a downstream `dmux4way`-style distributor can route on `out_sel` to recover the original channel. It sits between per-channel producers and a single shared consumer.

## Interface
- `WIDTH`, default 4: data width per channel, in bits.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 4: per-channel valid. Bit i belongs to channel i.
- `in_ready` out 4: per-channel ready. A transfer on channel i occurs when `in_valid[i] && in_ready[i]`.
- `in_data` in 4*WIDTH: channel i data sits at `[i*WIDTH +: WIDTH]`.
- `out_valid` out 1: the output register holds a beat.
- `out_ready` in 1: the consumer accepts the beat.
- `out_data` out WIDTH: data of the held beat.
- `out_sel` out 2: source channel index of the held beat.

## Operation
- Output register states:
  - EMPTY: `out_valid` = 0.
  - FULL: `out_valid` = 1.
- `load = !out_valid || out_ready`. The register can take a new beat when it is empty or is being drained in the same cycle.
- Arbitration is combinational from `in_valid` and the 2-bit pointer `ptr`.
  - Search order: `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
  - The first requesting channel in that order is the grant `g`.
- `in_ready[i] = load && (i == g) && any(in_valid)`. At most one bit of `in_ready` is high per cycle.
- On a transfer, at the next edge:
  - `out_data` ← channel g data
  - `out_sel` ← g
  - `out_valid` ← 1
  - `ptr` ← (g+1) mod 4
- When `out_ready` is high and no input transfers: `out_valid` ← 0, and `out_data`/`out_sel` hold their values.
- When `out_valid` is high and `out_ready` is low:
  - `out_data` and `out_sel` hold stable.
  - `in_ready` is all zeros.
- `ptr` changes only on a transfer. Idle cycles never advance it.
- Simultaneous drain and fill (FULL, `out_ready`=1, some `in_valid`=1): the new beat replaces the old one with no bubble, and the state stays FULL.
- Wrap-around: a grant to channel 3 sets `ptr` to 0.

## Timing
- Reset (`rst_n`=0 at an edge):
  - `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0.
  - `in_ready` is forced to 0 while `rst_n` is low.
- Reset mid-operation discards the held beat. No transfer is reported in the reset cycle.
- Latency: a beat accepted at edge N is visible on `out_*` after edge N and can be consumed at edge N+1.
- Throughput: one beat per cycle while `out_ready` stays high.
- No combinational path from `in_data` to `out_data`.
- `in_ready` depends combinationally on `out_ready`, `out_valid`, `in_valid` and `ptr`.
- Producers must hold `in_valid` and `in_data` stable until the transfer.

## Configuration
- `MUX4WAY_FIXED_PRIO_EN`
  - Defined: fixed priority, where channel 0 is highest and channel 3 lowest. `ptr` is not implemented and the search always starts at 0.
  - Not defined (default): round-robin as described in Operation.
  - Handshake, latency and reset behaviour are identical in both builds.

## Structure
- Package `mux4way_pkg`:
  - `CH_NUM` = 4 and `SEL_W` = 2.
  - Output state enum {EMPTY, FULL}.
  - A function returning the next round-robin index.
- Sub-module `rr_arbiter4`:
  - Inputs: `req[3:0]` and `ptr[1:0]`.
  - Outputs: a one-hot `gnt[3:0]` and `gnt_idx[1:0]`.
  - Purely combinational. The fixed-priority variant is selected inside it by the macro.
- The top holds the output register and `ptr`.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with all `in_valid`=1 → `in_ready`=0000, `out_valid`=0, `out_sel`=0, `out_data`=0.
- Single channel: `in_valid`=0100 with data 0xA, `out_ready`=1 → one cycle later `out_valid`=1, `out_data`=0xA, `out_sel`=2, and `ptr` is 3.
- Round-robin fairness: `in_valid`=1111 held, `out_ready`=1, data i = i+5 → `out_sel` sequence 0,1,2,3,0, `out_data` 5,6,7,8,5, no bubbles. With the macro defined, the sequence is 0,0,0,0.
- Backpressure: `out_valid`=1, `out_ready`=0 for 3 cycles with `in_valid`=0011 → `in_ready`=0000 and `out_data`/`out_sel` stable. On release, the next beat comes from the channel after the held one.
- Wrap and skip: `ptr`=3, `in_valid`=0010 → grant to channel 1, then `ptr`=2. Next `in_valid`=1001 → grant to channel 3, then `ptr`=0.
- Reset mid-stream: assert `rst_n`=0 while FULL with `out_ready`=0 → next cycle `out_valid`=0. After release with `in_valid`=1111 the first grant is channel 0.

Source files
------------

// File: rtl/mux4way_pkg.sv
// Shared types and helpers for the 4-way round-robin collector.
// Build option: MUX4WAY_FIXED_PRIO_EN selects fixed priority arbitration.
package mux4way_pkg;

    localparam int CH_NUM = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    function automatic logic [SEL_W-1:0] rr_next(
        input logic [SEL_W-1:0] idx
    );
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-request arbiter searching from ptr upward, mod 4.
// With MUX4WAY_FIXED_PRIO_EN the search always starts at channel 0.
module rr_arbiter4
    import mux4way_pkg::*;
(
    input  logic [CH_NUM-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [CH_NUM-1:0] gnt,
    output logic [SEL_W-1:0]  gnt_idx
);

    logic [SEL_W-1:0] base;
    logic [SEL_W-1:0] idx;
    logic             found;

`ifdef MUX4WAY_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
    assign base = '0;
`else
    assign base = ptr;
`endif

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < CH_NUM; k++) begin
            idx = base + SEL_W'(k);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux4way_rr.sv
// Four-channel collector with a registered output beat tagged by source.
// Build option: MUX4WAY_FIXED_PRIO_EN drops the pointer for fixed priority.
module mux4way_rr
    import mux4way_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CH_NUM-1:0]       in_valid,
    output logic [CH_NUM-1:0]       in_ready,
    input  logic [CH_NUM*WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel
);

    out_state_e state_q;
    out_state_e state_d;

    logic [CH_NUM-1:0] gnt;
    logic [SEL_W-1:0]  gnt_idx;
    logic [SEL_W-1:0]  ptr;
    logic              load;
    logic              xfer;

    rr_arbiter4 u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign out_valid = (state_q == FULL);
    assign load      = !out_valid || out_ready;
    assign in_ready  = (rst_n && load) ? gnt : '0;
    assign xfer      = |(in_valid & in_ready);

    always_comb begin
        state_d = state_q;
        if (xfer) begin
            state_d = FULL;
        end else if (out_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            out_sel  <= '0;
        end else if (xfer) begin
            out_data <= in_data[gnt_idx*WIDTH +: WIDTH];
            out_sel  <= gnt_idx;
        end
    end

`ifdef MUX4WAY_FIXED_PRIO_EN
    assign ptr = '0;
`else
    // Pointer moves only on a transfer so idle cycles keep fairness.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (xfer) begin
            ptr <= rr_next(gnt_idx);
        end
    end
`endif

endmodule
